// File: rtl/prio_code_decoder.sv
// Receives 2-bit priority codes over valid/ready, buffers them in a FIFO and
// replays each one as a timed one-hot pulse on a_out/b_out/c_out.
module prio_code_decoder #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               code_in,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic                     a_out,
  output logic                     b_out,
  output logic                     c_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               event_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   =
    CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    head;
  logic          push;
  logic          pop;

  assign code_ready = (count != FULL_CNT);
  assign push       = code_valid && code_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_out       <= 1'b0;
      b_out       <= 1'b0;
      c_out       <= 1'b0;
      event_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop && head != 2'b00) begin
            a_out       <= (head == 2'b11);
            b_out       <= (head == 2'b10);
            c_out       <= (head == 2'b01);
            cnt         <= PULSE_LOAD;
            state       <= PULSE;
            event_count <= event_count + 8'd1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            a_out <= 1'b0;
            b_out <= 1'b0;
            c_out <= 1'b0;
            cnt   <= GAP_LOAD;
            state <= (GAP_LEN == 0) ? IDLE : GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Bench for prio_code_decoder: directed pushes, a cycle-level reference
// model compared every cycle, and literal expectations for key timings.
module tb_prio_code_decoder;

  localparam int DEPTH = 4;
  localparam int PL    = 2;
  localparam int GL    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] code_in = 2'b00;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] event_count;

  prio_code_decoder #(
    .DEPTH(DEPTH),
    .PULSE_LEN(PL),
    .GAP_LEN(GL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .code_in(code_in),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .a_out(a_out),
    .b_out(b_out),
    .c_out(c_out),
    .busy(busy),
    .fifo_count(fifo_count),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a queue of codes and a count of cycles the current
  // emission still occupies (pulse cycles followed by gap cycles).
  logic [1:0] mq[$];
  int         occ = 0;
  logic [1:0] mcur = 2'b00;
  int         mev = 0;
  logic [1:0] popped;
  bit         mpush;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      occ  = 0;
      mcur = 2'b00;
      mev  = 0;
    end else begin
      mpush = code_valid && (mq.size() < DEPTH);
      if (occ == 0 && mq.size() > 0) begin
        popped = mq.pop_front();
        if (popped != 2'b00) begin
          occ  = PL + GL;
          mcur = popped;
          mev  = (mev + 1) % 256;
        end
      end else if (occ > 0) begin
        occ--;
      end
      if (mpush) mq.push_back(code_in);
    end
  end

  function automatic int model_vec();
    bit on;
    on = (occ > GL);
    return {mq.size() < DEPTH,
            on && mcur == 2'b11,
            on && mcur == 2'b10,
            on && mcur == 2'b01,
            (occ > 0) || (mq.size() > 0),
            3'(mq.size()),
            8'(mev)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("model_compare",
            {code_ready, a_out, b_out, c_out, busy, fifo_count, event_count},
            model_vec());
      if (a_out + b_out + c_out > 1)
        check("one_hot", a_out + b_out + c_out, 1);
    end
  end

  // Rise monitor and fifo occupancy tracking.
  int         rise_code[$];
  int         rise_cyc[$];
  logic       pa = 0, pb = 0, pc = 0;
  int         peak = 0;
  bit         saw_full = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_out && !pa) begin rise_code.push_back(3); rise_cyc.push_back(cyc); end
      if (b_out && !pb) begin rise_code.push_back(2); rise_cyc.push_back(cyc); end
      if (c_out && !pc) begin rise_code.push_back(1); rise_cyc.push_back(cyc); end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (fifo_count == 3'd4 && !code_ready) saw_full = 1;
    end
    pa = a_out;
    pb = b_out;
    pc = c_out;
  end

  int last_push_cyc = 0;

  task automatic send(input logic [1:0] c);
    int n = 0;
    @(negedge clk);
    code_in    = c;
    code_valid = 1'b1;
    while (!code_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_push_cyc = cyc;
    code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rise_code.delete();
    rise_cyc.delete();
    peak = 0;
    saw_full = 0;
  endtask

  int first_push;

  initial begin
    // Reset state
    #1;
    check("rst_ready", code_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_a", a_out, 0);
    check("rst_ev", event_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Lone 11 code
    send(2'b11);
    @(negedge clk);
    check("t1_a_before", a_out, 0);
    check("t1_count1", fifo_count, 1);
    @(negedge clk);
    check("t1_a_hi1", a_out, 1);
    check("t1_ev", event_count, 1);
    check("t1_count0", fifo_count, 0);
    @(negedge clk);
    check("t1_a_hi2", a_out, 1);
    @(negedge clk);
    check("t1_a_gap", a_out, 0);
    check("t1_busy_gap", busy, 1);
    @(negedge clk);
    check("t1_busy_end", busy, 0);
    check("t1_bc", {b_out, c_out}, 0);
    check("t1_rises", rise_code.size(), 1);

    // Back-to-back 11,10,01
    do_reset();
    send(2'b11);
    send(2'b10);
    send(2'b01);
    wait_idle();
    check("t2_rises", rise_code.size(), 3);
    if (rise_code.size() == 3) begin
      check("t2_ord0", rise_code[0], 3);
      check("t2_ord1", rise_code[1], 2);
      check("t2_ord2", rise_code[2], 1);
      check("t2_gap01", rise_cyc[1] - rise_cyc[0], 4);
      check("t2_gap12", rise_cyc[2] - rise_cyc[1], 4);
    end
    check("t2_peak", peak, 2);

    // Eight held codes overflow the FIFO
    do_reset();
    for (int i = 0; i < 8; i++) send(2'(3 - (i % 3)));
    wait_idle();
    check("t3_full_seen", saw_full, 1);
    check("t3_ev", event_count, 8);
    check("t3_rises", rise_code.size(), 8);
    for (int i = 0; i < 8 && i < rise_code.size(); i++)
      check("t3_order", rise_code[i], 3 - (i % 3));

    // 00 then 10
    do_reset();
    send(2'b00);
    first_push = last_push_cyc;
    send(2'b10);
    wait_idle();
    check("t4_rises", rise_code.size(), 1);
    if (rise_code.size() == 1) begin
      check("t4_code", rise_code[0], 2);
      check("t4_lat", rise_cyc[0] - first_push, 2);
    end
    check("t4_ev", event_count, 1);

    // Asynchronous reset during an a pulse with 3 queued
    do_reset();
    send(2'b01);
    send(2'b11);
    send(2'b10);
    send(2'b01);
    send(2'b10);
    @(negedge clk);
    check("t5_full", fifo_count, 4);
    @(negedge clk);
    check("t5_a_on", a_out, 1);
    check("t5_queued", fifo_count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_a", a_out, 0);
    check("t5_async_cnt", fifo_count, 0);
    check("t5_async_ev", event_count, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", code_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    rise_code.delete();
    repeat (12) @(negedge clk);
    check("t5_no_pulse", rise_code.size(), 0);
    check("t5_ev_after", event_count, 0);

    // event_count wrap
    do_reset();
    for (int i = 0; i < 256; i++) send(2'b11);
    wait_idle();
    check("t6_wrap", event_count, 0);
    check("t6_rises", rise_code.size(), 256);
    send(2'b01);
    wait_idle();
    check("t6_257", event_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prio_code_decoder.md
Name: prio_code_decoder

Overview:
- Counterpart to the team's 3-input priority encoder, which maps a,b,c to a 2-bit code q: a→11, b→10, c→01, none→00.
- Accepts a stream of those 2-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as a timed one-hot pulse on a_out/b_out/c_out, separated by a programmable idle gap.
- Sits at the receiving end of the encoded request link and regenerates the original request lines for downstream logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PULSE_LEN, 2, cycles each decoded output stays high; ≥1.
- GAP_LEN, 1, forced-low cycles after each pulse; ≥0 (0 = no gap).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- code_in  input  2  encoded request: 11=a, 10=b, 01=c, 00=none.
- code_valid  input  1  code_in valid this cycle.
- code_ready  output  1  FIFO can accept; equals !full.
- a_out  output  1  decoded request a pulse.
- b_out  output  1  decoded request b pulse.
- c_out  output  1  decoded request c pulse.
- busy  output  1  high when state != IDLE or fifo_count != 0.
- fifo_count  output  $clog2(DEPTH)+1  entries currently held.
- event_count  output  8  pulses emitted; wraps 255→0.

Behaviour:
- Reset:
  - rst asserted immediately clears FIFO pointers and count, sets state=IDLE, and zeroes a_out/b_out/c_out, event_count and the pulse/gap counter.
  - code_ready=1 during and after reset; busy=0.
  - Codes pending at reset are discarded.
- Push: a write occurs on a rising edge with code_valid && code_ready. When full, code_ready=0 even if a pop happens on the same edge, so the push is blocked that cycle.
- Pop: performed only by the FSM in IDLE when fifo_count != 0. A simultaneous push and pop leaves fifo_count unchanged.
- FSM states: IDLE, PULSE, GAP.
  - IDLE, FIFO empty: remain in IDLE; outputs 0.
  - IDLE, FIFO non-empty: pop the head on this edge.
    - Head 00: discard, remain in IDLE, no output change (one cycle per 00 code).
    - Otherwise: register the one-hot output on the same edge (11→a_out, 10→b_out, 01→c_out), load the counter with PULSE_LEN-1, go to PULSE, increment event_count.
  - PULSE: hold outputs. At counter==0, clear outputs on the edge and go to GAP with counter=GAP_LEN-1, or go to IDLE if GAP_LEN==0. Otherwise decrement the counter.
  - GAP: outputs 0. At counter==0 go to IDLE; otherwise decrement.
- Outputs are registered; at most one of a_out/b_out/c_out is ever high.
- Latency: a code pushed at edge k into an empty FIFO while IDLE is popped at edge k+1. Its output is high from edge k+1 through edge k+1+PULSE_LEN, i.e. PULSE_LEN cycles.
- Throughput: one non-zero code per PULSE_LEN+GAP_LEN+1 cycles. The extra cycle is the IDLE pop cycle.
- FIFO ordering: strict first-in first-out; no loss or duplication under any push pattern.
- Pointer wrap-around: natural modulo DEPTH.
- event_count wraps 255→0 with no flag.

Test Plan:
- Defaults, push 11 at edge 0 → a_out high for exactly 2 cycles starting after edge 1, low for ≥1 cycle, b_out/c_out stay 0, event_count=1, busy falls after the gap.
- Push 11,10,01 on consecutive edges → a, b, c pulses each 2 cycles long, rising edges 4 cycles apart, order preserved, fifo_count peaks at 2.
- Hold code_valid=1 for 8 codes (values cycling 11,10,01) while decoder busy → code_ready drops when fifo_count==4; all 8 pulses appear in order; event_count=8.
- Push 00 then 10 → no pulse for 00; b_out rises one cycle later than a lone 10 would; event_count=1.
- Assert rst mid a_out pulse with 3 codes queued → a_out=0 and fifo_count=0 without waiting for a clock edge; event_count=0; after release no pulses appear until a new push.
- Emit 256 pulses → event_count returns to 0; the 257th pulse gives 1.
